// File: rtl/yarvi_mem_arb.sv
// yarvi_mem_arb: arbitrates execute (X) and fetch (F) requests onto the single me port and routes read returns.
// Optional YARVI_MEM_ARB_FAIR_EN forces an F grant after STARVE_LIMIT consecutive X grants while F waits.
module yarvi_mem_arb #(
  parameter int VW = 32,
  parameter int XW = 64,
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic          x_writeenable,
  input  logic [VW-1:0] x_address,
  input  logic [XW-1:0] x_writedata,
  input  logic [1:0]    x_sizelg2,
  input  logic [4:0]    x_readtag,
  input  logic          x_readsignextend,
  input  logic          f_valid,
  output logic          f_ready,
  input  logic [VW-1:0] f_address,
  input  logic [4:0]    f_readtag,
  output logic          mem_valid,
  output logic          mem_writeenable,
  output logic [VW-1:0] mem_address,
  output logic [XW-1:0] mem_writedata,
  output logic [1:0]    mem_sizelg2,
  output logic [4:0]    mem_readtag,
  output logic          mem_readsignextend,
  input  logic          me_ready,
  input  logic          me_readdatavalid,
  input  logic [4:0]    me_readdatatag,
  input  logic [XW-1:0] me_readdata,
  output logic          x_rdvalid,
  output logic          f_rdvalid,
  output logic [4:0]    x_rdtag,
  output logic [4:0]    f_rdtag,
  output logic [XW-1:0] x_rddata,
  output logic [XW-1:0] f_rddata,
  output logic          err_orphan
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("yarvi_mem_arb: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [CW-1:0] credit;
  logic [PW-1:0] wptr, rptr;
  logic [DEPTH-1:0] owner;
  logic [4:0] rd_tag;
  logic [XW-1:0] rd_data;
  logic loadable, x_elig, f_elig, f_win, push, pop, empty, head;

  assign loadable = !mem_valid || me_ready;
  assign x_elig = x_valid && (x_writeenable || credit < FULL);
  assign f_elig = f_valid && credit < FULL;
  assign x_ready = loadable && x_elig && !f_win;
  assign f_ready = loadable && f_win;
  assign empty = credit == '0;
  assign push = (x_ready && !x_writeenable) || f_ready;
  assign pop = me_readdatavalid && !empty;
  assign head = owner[rptr];
  assign x_rdtag = rd_tag;
  assign f_rdtag = rd_tag;
  assign x_rddata = rd_data;
  assign f_rddata = rd_data;

`ifdef YARVI_MEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve;
  assign f_win = f_elig && (!x_elig || starve == LIMIT);
  // Counter holds while the port is stalled so a waiting F keeps its accrued claim.
  always_ff @(posedge clock) begin
    if (!reset_n) starve <= '0;
    else if (!f_elig || f_ready) starve <= '0;
    else if (x_ready) starve <= starve + SW'(1);
  end
`else
  assign f_win = f_elig && !x_elig;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      credit <= '0;
      wptr <= '0;
      rptr <= '0;
      x_rdvalid <= 1'b0;
      f_rdvalid <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      mem_valid <= (x_ready || f_ready) ? 1'b1 : me_ready ? 1'b0 : mem_valid;
      credit <= (push && !pop) ? credit + CW'(1) : (pop && !push) ? credit - CW'(1) : credit;
      wptr <= push ? wptr + PW'(1) : wptr;
      rptr <= pop ? rptr + PW'(1) : rptr;
      x_rdvalid <= pop && !head;
      f_rdvalid <= pop && head;
      err_orphan <= err_orphan || (me_readdatavalid && empty);
    end
  end

  always_ff @(posedge clock) begin
    if (x_ready || f_ready) begin
      mem_writeenable <= x_ready && x_writeenable;
      mem_address <= x_ready ? x_address : f_address;
      mem_writedata <= x_ready ? x_writedata : '0;
      mem_sizelg2 <= x_ready ? x_sizelg2 : 2'd2;
      mem_readtag <= x_ready ? x_readtag : f_readtag;
      mem_readsignextend <= x_ready && x_readsignextend;
    end
    if (push) owner[wptr] <= f_ready;
    if (me_readdatavalid) begin
      rd_tag <= me_readdatatag;
      rd_data <= me_readdata;
    end
  end
endmodule

// File: doc/yarvi_mem_arb.md
Name: yarvi_mem_arb

Overview:
- Two-port arbiter sharing the single yarvi_me data-memory port between the execute stage (port X: loads/stores) and the fetch unit (port F: 32-bit instruction reads).
- Registers the winning request onto the me port and holds it until me_ready.
- Tracks ownership of outstanding reads in an in-order owner FIFO and routes me read data back to the owning requester.
- Sits between yarvi_ex/yarvi_fe and yarvi_me.

Parameters:
- VW, 32: virtual address width (`VMSB+1).
- XW, 64: data width (`XMSB+1).
- DEPTH, 4: maximum outstanding reads, power of two ≥2.
- STARVE_LIMIT, 3: consecutive X grants while F waits before F is forced (fair mode only).

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- x_valid  in  1  X request valid
- x_ready  out  1  X request accepted this cycle
- x_writeenable  in  1  1=store, 0=load
- x_address  in  VW  byte address
- x_writedata  in  XW  store data
- x_sizelg2  in  2  log2 access size
- x_readtag  in  5  load tag
- x_readsignextend  in  1  load sign-extend
- f_valid  in  1  F read request valid
- f_ready  out  1  F request accepted this cycle
- f_address  in  VW  fetch address
- f_readtag  in  5  fetch tag
- mem_valid  out  1  request to me
- mem_writeenable  out  1  to me
- mem_address  out  VW  to me
- mem_writedata  out  XW  to me
- mem_sizelg2  out  2  to me
- mem_readtag  out  5  to me
- mem_readsignextend  out  1  to me
- me_ready  in  1  me accepts mem_* this cycle
- me_readdatavalid  in  1  read data returning, strictly in request order
- me_readdatatag  in  5  returned tag
- me_readdata  in  XW  returned data
- x_rdvalid / f_rdvalid  out  1  routed read return
- x_rdtag / f_rdtag  out  5  routed tag
- x_rddata / f_rddata  out  XW  routed data
- err_orphan  out  1  sticky: read data returned with owner FIFO empty

Behaviour:
- Reset (reset_n=0 at clock edge), all cycle-synchronous:
  - mem_valid=0, x_rdvalid=f_rdvalid=0, err_orphan=0.
  - Owner FIFO empty, credit count=0, starve counter=0.
  - Other mem_* and rd* data outputs are don't-care.
  - Reset mid-transaction discards the held request and all outstanding ownership.
- Output register:
  - Loadable when mem_valid=0, or mem_valid=1 && me_ready=1.
  - A loaded request appears on mem_* the cycle after x_ready/f_ready: 1-cycle latency.
  - mem_* are stable while mem_valid && !me_ready.
- Grant, evaluated combinationally when loadable:
  - Eligible X: x_valid && (x_writeenable || credit<DEPTH).
  - Eligible F: f_valid && credit<DEPTH.
  - Default priority: X over F.
  - At most one ready asserted per cycle; no ready while not loadable.
- F fields: sizelg2=2, writeenable=0, readsignextend=0, writedata=0.
- Credit and owner FIFO:
  - Loading a read pushes the owner bit (0=X, 1=F) and increments credit.
  - me_readdatavalid pops the FIFO and decrements credit.
  - Simultaneous push and pop leaves credit unchanged.
  - Credit==DEPTH blocks reads only; stores still proceed.
- Return routing, registered 1 cycle:
  - On the edge after me_readdatavalid, exactly one of x_rdvalid/f_rdvalid pulses for one cycle, selected by the popped owner.
  - rdtag/rddata carry me_readdatatag/me_readdata.
  - Returns are never stalled: requesters must sink them.
- Orphan return: me_readdatavalid with FIFO empty drops the data, sets err_orphan until reset, and leaves credit at 0 (no underflow).

Optional Feature:
- YARVI_MEM_ARB_FAIR_EN defined:
  - Starve counter increments on each X grant while F eligible and not granted.
  - It resets to 0 on any F grant, or when F is not eligible.
  - When counter==STARVE_LIMIT, F wins over eligible X.
- Undefined: strict X priority, no counter logic; F can starve indefinitely.

Test Plan:
- Reset, then F read addr 0x100 tag 3, me_ready=1:
  - f_ready cycle 0; mem_valid, address 0x100, sizelg2=2, readtag 3 at cycle 1.
  - me returns data 0xDEAD tag 3 → f_rdvalid=1 with 0xDEAD one cycle later; x_rdvalid stays 0.
- X store and F read both valid, me_ready=0 for 3 cycles:
  - Store is granted first; mem_* held constant 3 cycles.
  - F granted on the cycle me_ready rises; store does not touch credit.
- Issue 4 X loads, no returns:
  - Credit=4; 5th load and F read get no ready; X store still gets x_ready.
  - One return → next load accepted the following cycle.
- Interleaved X,F,X reads returned in order → x_rdvalid, f_rdvalid, x_rdvalid pulses in that order with matching tags.
- FAIR_EN, STARVE_LIMIT=3, X and F continuously valid:
  - Grant pattern X,X,X,F repeating.
  - Without the macro: F never granted.
- me_readdatavalid with no outstanding read → err_orphan=1 and stays 1, no rdvalid, credit 0. reset_n=0 mid-transaction with 2 outstanding → mem_valid=0, credit 0, err_orphan 0 next cycle.
